// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host controller.
//   State encodings for the top-level FSM, status register bit positions,
//   the PS/2 frame length and an odd-parity helper.
package ps2_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE         = 3'd0;
  localparam state_t S_RX_BITS      = 3'd1;
  localparam state_t S_RX_WAIT_FULL = 3'd2;
  localparam state_t S_TX_INHIBIT   = 3'd3;
  localparam state_t S_TX_START     = 3'd4;
  localparam state_t S_TX_BITS      = 3'd5;
  localparam state_t S_TX_ACK       = 3'd6;

  localparam int ST_NE   = 0;
  localparam int ST_PAR  = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_TXB  = 3;
  localparam int ST_TXE  = 4;
  localparam int ST_PERR = 5;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Receive FIFO for the PS/2 host: W bits wide, DEPTH entries (power of two).
// Ports:
//   clk, n_rst          system clock, synchronous active-low reset
//   push, wdata         write an entry (ignored when full unless popping too)
//   pop                 drop the head entry (ignored when empty)
//   flush               empty the FIFO; overrides push and pop
//   rdata               head entry (show-ahead)
//   full, empty, count  occupancy
module ps2_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  import ps2_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_host_fifo.sv
// PS/2 host controller with a DEPTH-entry receive FIFO and host-to-device
// transmit, on an 8-bit CPU I/O bus.
// Ports:
//   clk, n_rst            system clock, synchronous active-low reset
//   d, a                  bus data (driven only on n_sel=0 & n_oe=0), register select
//   n_sel, n_oe, n_we     chip select, read and write strobes (active-low)
//   rdy                   access acknowledge
//   clk_in, data_in       PS/2 clock/data lines (asynchronous)
//   n_clk_out, n_data_out 1 = pull the PS/2 line low
// Build option: PS2_PARITY_DROP_EN drops bad-parity frames and keeps a sticky
// parity-error flag in status[5].
//
// state          | meaning
// S_IDLE         | lines released, waiting for a start bit or a tx request
// S_RX_BITS      | shifting in data/parity/stop bits
// S_RX_WAIT_FULL | FIFO full, device inhibited until a pop or flush
// S_TX_INHIBIT   | clock held low before transmit
// S_TX_START     | data pulled low (start bit), clock released
// S_TX_BITS      | driving data, parity, stop on device clock falls
// S_TX_ACK       | sampling the device ack bit
module ps2_host_fifo #(
  parameter int DEPTH       = 4,
  parameter int INHIBIT_CYC = 120,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       clk,
  input  logic       n_rst,
  inout  wire  [7:0] d,
  input  logic       a,
  input  logic       n_sel,
  input  logic       n_oe,
  input  logic       n_we,
  output logic       rdy,
  input  logic       clk_in,
  input  logic       data_in,
  output logic       n_clk_out,
  output logic       n_data_out
);
  import ps2_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int INH_W = $clog2(INHIBIT_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [AW:0]      CNT_LAST = (AW+1)'(DEPTH - 1);
  localparam logic [3:0]       STOP_IDX = 4'(FRAME_LEN - 1);

  logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2, fall;
  logic rd_now, wr_now, rd_q, wr_q, a_q;
  logic [7:0] wdat_q, status, rd_data;
  logic data_wr, ctrl_wr, tx_go;

  state_t            state;
  logic [3:0]        bit_cnt;
  logic [8:0]        rx_sh;
  logic [9:0]        tx_frame;
  logic [INH_W-1:0]  inh_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tx_err, ovf, tx_busy, timed, tmo_hit;
  logic              stop_ok, rx_par_ok, rx_push, rx_full_after;

  logic [8:0]        fifo_rdata;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic [AW:0]       fifo_count;

  // synchronisers reset high so an idle bus gives no false edge after reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      {clk_s1, clk_s2, clk_s3} <= 3'b111;
      {dat_s1, dat_s2}         <= 2'b11;
    end else begin
      {clk_s3, clk_s2, clk_s1} <= {clk_s2, clk_s1, clk_in};
      {dat_s2, dat_s1}         <= {dat_s1, data_in};
    end
  end
  assign fall = clk_s3 & ~clk_s2;

  // bus: actions fire on the sampled strobe release, one per access
  assign rd_now = ~n_sel & ~n_oe;
  assign wr_now = ~n_sel & ~n_we;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rd_q <= 1'b0; wr_q <= 1'b0; rdy <= 1'b0; a_q <= 1'b0; wdat_q <= '0;
    end else begin
      rd_q <= rd_now;
      wr_q <= wr_now;
      rdy  <= rd_now | wr_now;
      if (rd_now | wr_now) a_q <= a;
      if (wr_now) wdat_q <= d;
    end
  end

  assign data_wr    = wr_q & ~wr_now & ~a_q;
  assign ctrl_wr    = wr_q & ~wr_now &  a_q;
  assign fifo_pop   = rd_q & ~rd_now & ~a_q;
  assign fifo_flush = ctrl_wr & wdat_q[ST_NE];
  assign tx_go      = data_wr & (state == S_IDLE || state == S_RX_WAIT_FULL);

  // receive path
  assign rx_par_ok = ^rx_sh;
  assign stop_ok   = (state == S_RX_BITS) & fall & (bit_cnt == STOP_IDX) & dat_s2;
`ifdef PS2_PARITY_DROP_EN
  assign rx_push = stop_ok & rx_par_ok;
`else
  assign rx_push = stop_ok;
`endif
  assign rx_full_after = ~fifo_flush & ~fifo_pop &
                         (fifo_full | (rx_push & (fifo_count == CNT_LAST)));

  ps2_rx_fifo #(.DEPTH(DEPTH), .W(9)) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (rx_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata ({rx_par_ok, rx_sh[7:0]}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign timed   = (state == S_RX_BITS) || (state == S_TX_BITS) || (state == S_TX_ACK);
  assign tmo_hit = timed & ~fall & (tmo_cnt == '0);
  assign tx_busy = (state == S_TX_INHIBIT) || (state == S_TX_START) ||
                   (state == S_TX_BITS) || (state == S_TX_ACK);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      rx_sh    <= '0;
      tx_frame <= '0;
      inh_cnt  <= '0;
      tmo_cnt  <= TMO_LOAD;
      n_data_out <= 1'b0;
      tx_err   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (!timed || fall) tmo_cnt <= TMO_LOAD;
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

      if (ctrl_wr && wdat_q[ST_OVF]) ovf <= 1'b0;
      if (rx_push && fifo_full && !fifo_pop && !fifo_flush) ovf <= 1'b1;

      // sets below override a same-cycle clear
      if (ctrl_wr && wdat_q[ST_TXE]) tx_err <= 1'b0;
      if (data_wr && !tx_go) tx_err <= 1'b1;

      if (tx_go) begin
        tx_frame <= {1'b1, odd_par(wdat_q), wdat_q};
        inh_cnt  <= INH_LOAD;
        state    <= S_TX_INHIBIT;
      end else begin
        case (state)
          S_IDLE: begin
            n_data_out <= 1'b0;
            if (fall && !dat_s2) begin
              bit_cnt <= 4'd1;
              state   <= S_RX_BITS;
            end
          end
          S_RX_BITS: begin
            if (tmo_hit) state <= S_IDLE;
            else if (fall) begin
              if (bit_cnt == STOP_IDX)
                state <= (dat_s2 && rx_full_after) ? S_RX_WAIT_FULL : S_IDLE;
              else begin
                rx_sh   <= {dat_s2, rx_sh[8:1]};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          S_RX_WAIT_FULL: begin
            if (fifo_pop || fifo_flush) state <= S_IDLE;
          end
          S_TX_INHIBIT: begin
            if (inh_cnt == '0) begin
              n_data_out <= 1'b1;
              state      <= S_TX_START;
            end else inh_cnt <= inh_cnt - 1'b1;
          end
          S_TX_START: begin
            bit_cnt <= '0;
            state   <= S_TX_BITS;
          end
          S_TX_BITS: begin
            if (tmo_hit) begin
              n_data_out <= 1'b0;
              tx_err     <= 1'b1;
              state      <= S_IDLE;
            end else if (fall) begin
              n_data_out <= ~tx_frame[bit_cnt];
              if (bit_cnt == 4'd9) state <= S_TX_ACK;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_TX_ACK: begin
            if (tmo_hit) begin
              tx_err <= 1'b1;
              state  <= S_IDLE;
            end else if (fall) begin
              if (dat_s2) tx_err <= 1'b1;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign n_clk_out = (state == S_RX_WAIT_FULL) || (state == S_TX_INHIBIT);

`ifdef PS2_PARITY_DROP_EN
  logic perr;
  always_ff @(posedge clk) begin
    if (!n_rst) perr <= 1'b0;
    else begin
      if (ctrl_wr && wdat_q[ST_PERR]) perr <= 1'b0;
      if (stop_ok && !rx_par_ok) perr <= 1'b1;
    end
  end
`endif

  always_comb begin
    status          = '0;
    status[ST_NE]   = ~fifo_empty;
`ifdef PS2_PARITY_DROP_EN
    status[ST_PAR]  = 1'b1;
    status[ST_PERR] = perr;
`else
    status[ST_PAR]  = ~fifo_empty & fifo_rdata[8];
`endif
    status[ST_OVF]  = ovf;
    status[ST_TXB]  = tx_busy;
    status[ST_TXE]  = tx_err;
    rd_data = a ? status : (fifo_empty ? 8'h00 : fifo_rdata[7:0]);
  end

  assign d = rd_now ? rd_data : 8'hzz;

endmodule

// File: tb/tb_ps2_host_fifo.sv
// Scoreboard bench for ps2_host_fifo: bus reads queue their expected byte,
// a monitor compares whenever rdy is up on a read. PS/2 device is modelled
// by tasks that toggle clk_in/data_in.
module tb_ps2_host_fifo;
  logic clk = 1'b0, n_rst = 1'b0;
  wire  [7:0] d;
  logic a = 1'b0, n_sel = 1'b1, n_oe = 1'b1, n_we = 1'b1;
  logic rdy, n_clk_out, n_data_out;
  logic clk_in = 1'b1, data_in = 1'b1;
  logic [7:0] d_drv = 8'h00;
  logic d_en = 1'b0;

  assign d = d_en ? d_drv : 8'hzz;
  always #5 clk = ~clk;

`ifdef PS2_PARITY_DROP_EN
  localparam logic [7:0] PAR1 = 8'h02;
`else
  localparam logic [7:0] PAR1 = 8'h00;
`endif
  localparam int HALF = 15;

  int vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  string      name_q[$];
  logic       seen = 1'b0;

  ps2_host_fifo #(.DEPTH(4), .INHIBIT_CYC(120), .TIMEOUT_CYC(2000)) dut (
    .clk(clk), .n_rst(n_rst), .d(d), .a(a), .n_sel(n_sel), .n_oe(n_oe),
    .n_we(n_we), .rdy(rdy), .clk_in(clk_in), .data_in(data_in),
    .n_clk_out(n_clk_out), .n_data_out(n_data_out)
  );

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bounded wait expired", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) tick();
  endtask

  // monitor: one comparison per read access, taken while rdy is high
  always @(negedge clk) begin
    if (rdy && !n_sel && !n_oe) begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) fail("unexpected_read");
        else check(name_q.pop_front(), {8'h00, d}, {8'h00, exp_q.pop_front()});
      end
    end else if (!rdy) seen = 1'b0;
  end

  task automatic bus_read(logic aa, logic [7:0] e, string nm);
    int n;
    exp_q.push_back(e);
    name_q.push_back(nm);
    a = aa; n_sel = 1'b0; n_oe = 1'b0;
    n = 0;
    while (!rdy && n < 10) begin tick(); n++; end
    if (!rdy) fail({nm, "_rdy_rise"});
    wait_cyc(2);
    n_oe = 1'b1; n_sel = 1'b1;
    n = 0;
    while (rdy && n < 10) begin tick(); n++; end
    if (rdy) fail({nm, "_rdy_fall"});
  endtask

  task automatic bus_write(logic aa, logic [7:0] v);
    int n;
    a = aa; d_drv = v; d_en = 1'b1; n_sel = 1'b0; n_we = 1'b0;
    n = 0;
    while (!rdy && n < 10) begin tick(); n++; end
    if (!rdy) fail("write_rdy_rise");
    tick();
    n_we = 1'b1; n_sel = 1'b1;
    n = 0;
    while (rdy && n < 10) begin tick(); n++; end
    if (rdy) fail("write_rdy_fall");
    d_en = 1'b0;
  endtask

  task automatic ps2_bit(logic b);
    data_in = b;
    wait_cyc(HALF);
    clk_in = 1'b0;
    wait_cyc(HALF);
    clk_in = 1'b1;
  endtask

  task automatic ps2_send(logic [7:0] b, logic par_good);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_good ? ~^b : ^b);
    ps2_bit(1'b1);
    data_in = 1'b1;
    wait_cyc(10);
  endtask

  task automatic tx_check(logic [7:0] b, logic ack);
    int cnt;
    logic [9:0] frame;
    frame = {1'b1, ~^b, b};
    bus_write(1'b0, b);
    cnt = 0;
    @(negedge clk);
    while (n_clk_out && cnt < 500) begin cnt++; @(negedge clk); end
    check("tx_inhibit_cycles", 16'(cnt), 16'd120);
    check("tx_start_data_low", {15'h0, n_data_out}, 16'h1);
    for (int k = 0; k < 10; k++) begin
      wait_cyc(HALF);
      clk_in = 1'b0;
      wait_cyc(HALF);
      check($sformatf("tx_bit%0d", k), {15'h0, n_data_out}, {15'h0, ~frame[k]});
      clk_in = 1'b1;
    end
    data_in = ack ? 1'b0 : 1'b1;
    wait_cyc(HALF);
    clk_in = 1'b0;
    wait_cyc(HALF);
    clk_in = 1'b1;
    data_in = 1'b1;
    wait_cyc(10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wait_cyc(5);
    check("rst_n_clk_out", {15'h0, n_clk_out}, 16'h0);
    check("rst_n_data_out", {15'h0, n_data_out}, 16'h0);
    check("rst_rdy", {15'h0, rdy}, 16'h0);
    vectors++;
    if (d !== 8'hzz) begin
      miscompares++;
      $display("FAIL rst_d_z: got %0h expected zz", d);
    end
    n_rst = 1'b1;
    wait_cyc(3);
    bus_read(1'b1, PAR1, "reset_status");

    ps2_send(8'hA5, 1'b1);
    bus_read(1'b1, 8'h03, "a5_status");
    bus_read(1'b0, 8'hA5, "a5_data");
    bus_read(1'b1, PAR1, "a5_status_after");

    ps2_send(8'h84, 1'b1);
    ps2_send(8'h02, 1'b1);
    ps2_send(8'hFF, 1'b1);
    check("not_full_after3", {15'h0, n_clk_out}, 16'h0);
    ps2_send(8'h00, 1'b1);
    check("full_inhibit", {15'h0, n_clk_out}, 16'h1);
    bus_read(1'b0, 8'h84, "full_data0");
    tick();
    @(negedge clk);
    check("full_release", {15'h0, n_clk_out}, 16'h0);
    bus_read(1'b0, 8'h02, "full_data1");
    bus_read(1'b0, 8'hFF, "full_data2");
    bus_read(1'b0, 8'h00, "full_data3");
    bus_read(1'b1, PAR1, "full_status_empty");
    bus_read(1'b0, 8'h00, "empty_data_read");

    ps2_send(8'h02, 1'b0);
`ifdef PS2_PARITY_DROP_EN
    bus_read(1'b1, 8'h22, "badpar_status");
    bus_write(1'b1, 8'h20);
    bus_read(1'b1, 8'h02, "badpar_cleared");
`else
    bus_read(1'b1, 8'h01, "badpar_status");
    bus_read(1'b0, 8'h02, "badpar_data");
    bus_read(1'b1, 8'h00, "badpar_after");
`endif

    ps2_send(8'h3C, 1'b1);
    bus_write(1'b1, 8'h01);
    bus_read(1'b1, PAR1, "flush_status");

    tx_check(8'hED, 1'b1);
    bus_read(1'b1, PAR1, "tx_ack_status");
    tx_check(8'hED, 1'b0);
    bus_read(1'b1, PAR1 | 8'h10, "tx_noack_status");
    bus_write(1'b1, 8'h10);
    bus_read(1'b1, PAR1, "tx_err_cleared");

    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    data_in = 1'b1;
    wait_cyc(2100);
    bus_read(1'b1, PAR1, "timeout_status");
    ps2_send(8'h55, 1'b1);
    bus_read(1'b1, 8'h03, "after_timeout_status");
    bus_read(1'b0, 8'h55, "after_timeout_data");

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin tick(); n++; end
    if (exp_q.size() != 0) fail("scoreboard_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ps2_host_fifo.md
Name: ps2_host_fifo

Overview:
Parametrised PS/2 host controller for the CPU's 8-bit I/O bus. It receives device frames into a DEPTH-entry FIFO and inhibits the device only when that FIFO is full. It also supports host-to-device transmission, replacing the single-byte receive-only controller. The block is fully synchronous to the system clock, and the PS/2 lines are oversampled.

Parameters:
DEPTH, 4, receive FIFO entries; power of two, 2..16
INHIBIT_CYC, 120, clk cycles the clock line is held low before a transmit (≥100 µs)
TIMEOUT_CYC, 2000, clk cycles without a PS/2 clock edge before an in-progress frame is abandoned

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
d  inout  8  data bus; driven only while n_sel=0 and n_oe=0
a  in  1  register select: 0=data, 1=status/control
n_sel  in  1  chip select, active-low
n_oe  in  1  read strobe, active-low
n_we  in  1  write strobe, active-low
rdy  out  1  access acknowledge
clk_in  in  1  PS/2 clock line (asynchronous)
data_in  in  1  PS/2 data line (asynchronous)
n_clk_out  out  1  1 = pull PS/2 clock low (external inverting open-drain)
n_data_out  out  1  1 = pull PS/2 data low

Behaviour:
- Reset (n_rst=0 at a clk edge): FIFO empty, overflow=0, tx_busy=0, tx_err=0, FSM=IDLE, n_clk_out=0, n_data_out=0, rdy=0, d=Z.
- Line sampling: clk_in and data_in each pass through a 2-flop synchroniser. A falling edge is synced-clk 1→0, detected one cycle later.
- rdy: rises the cycle after an active strobe (n_sel=0 and either n_oe=0 or n_we=0) is sampled. Falls the cycle after the strobe is released.
- Data read (a=0): d = FIFO head data. If empty, d=0x00. The pop happens on the cycle the n_oe release is sampled, so there is exactly one pop per access.
- Status read (a=1) bits:
  - [0] not-empty
  - [1] head parity ok
  - [2] overflow
  - [3] tx_busy
  - [4] tx_err (no device ack)
  - [7:5] = 0
- Status write (a=1) bits, acting on the n_we release:
  - d[0]=1 flushes the FIFO.
  - d[2]=1 clears overflow.
  - d[4]=1 clears tx_err.
- Data write (a=0): latches a tx byte and enters TX_INHIBIT if the FSM is in IDLE or RX_WAIT_FULL. Otherwise it is ignored and tx_err is set.
- FSM states: IDLE, RX_BITS, RX_WAIT_FULL, TX_INHIBIT, TX_START, TX_BITS, TX_ACK.
- IDLE:
  - Clock and data are released.
  - A falling edge with data=0 → RX_BITS with bit count 1.
  - A falling edge with data=1 is ignored as a glitch.
- RX_BITS:
  - Shift data on each falling edge: bits 1–8 are LSB first, bit 9 is parity (odd), bit 10 is stop.
  - After the stop bit, push {parity_ok, byte}.
  - If the FIFO is now full, go to RX_WAIT_FULL; else go to IDLE.
  - A stop bit of 0 discards the frame → IDLE.
  - Pushing into a full FIFO drops the byte and sets overflow. This is only possible after a flush race.
- RX_WAIT_FULL: n_clk_out=1 (inhibit). Leave for IDLE the cycle after any pop or flush.
- TX_INHIBIT: n_clk_out=1 for INHIBIT_CYC cycles → TX_START.
- TX_START: n_data_out=1, n_clk_out=0 → TX_BITS.
- TX_BITS:
  - On each falling edge, drive the next bit: bits 0–7, then odd parity, then stop (n_data_out=0).
  - After the stop edge → TX_ACK.
- TX_ACK: the next falling edge samples data. 0 = ack; 1 sets tx_err. Either way → IDLE.
- tx_busy=1 in all TX_* states.
- Timeout: in RX_BITS, TX_BITS or TX_ACK, TIMEOUT_CYC cycles with no falling edge → IDLE. The partial frame is discarded. A TX timeout sets tx_err.
- Simultaneous events:
  - A push and a pop in the same cycle keep the count unchanged.
  - A flush in the same cycle as a push wins, so the FIFO ends empty.
- Reset mid-frame: the next cycle is reset state, with the lines released.

Optional Feature:
PS2_PARITY_DROP_EN.
- Defined: frames with bad parity are not pushed. Status[1] always reads 1 and status[5] is a sticky parity-error flag, cleared by a status write with d[5]=1.
- Undefined: bad-parity frames are pushed with parity_ok=0, and status[5]=0.

Decomposition:
- Package ps2_pkg holds:
  - the state enum;
  - the status bit index constants (ST_NE, ST_PAR, ST_OVF, ST_TXB, ST_TXE, ST_PERR);
  - the frame length constant 11.
- One sub-module, ps2_rx_fifo: synchronous FIFO, 9 bits wide × DEPTH, with push/pop/flush and full/empty/count outputs.

Test Plan:
- Reset → status read = 0x00, n_clk_out=0, n_data_out=0, d=Z when idle.
- Receive 0xA5 with good parity, then read status and data → status 0x03, data 0xA5, status afterwards 0x00.
- DEPTH=4: receive 0x84, 0x02, 0xFF, 0x00 without reading → n_clk_out=1 after the 4th stop bit. The first read returns 0x84, n_clk_out=0 within 2 cycles, and later reads return the rest in order.
- Receive 0x02 with bad parity → status bit1=0 and data 0x02. With PS2_PARITY_DROP_EN: FIFO stays empty and status bit5=1.
- Write 0xED to data:
  - Expected line activity: n_clk_out=1 for 120 cycles, then n_data_out=1.
  - The bench clocks 11 edges, checking bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Bench ack of 0 → tx_err=0 and tx_busy=0. No ack → status 0x10.
- Stop clocking after 4 receive bits for more than 2000 cycles → FSM back in IDLE, no push. A fresh 0x55 frame is then received correctly.
